// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory request/response bus between the LSU and the memory system.
interface lsu_ctrl_if;
   logic        dmem_req_valid_o;
   logic        dmem_req_ready_i;
   logic        dmem_req_we_o;
   logic [63:0] dmem_req_addr_o;
   logic [63:0] dmem_req_wdata_o;
   logic [7:0]  dmem_req_be_o;
   logic        dmem_rsp_valid_i;
   logic [63:0] dmem_rsp_rdata_i;
   logic        dmem_rsp_err_i;
   modport master (
      output dmem_req_valid_o, dmem_req_we_o, dmem_req_addr_o, dmem_req_wdata_o, dmem_req_be_o,
      input  dmem_req_ready_i, dmem_rsp_valid_i, dmem_rsp_rdata_i, dmem_rsp_err_i
   );
   modport slave (
      input  dmem_req_valid_o, dmem_req_we_o, dmem_req_addr_o, dmem_req_wdata_o, dmem_req_be_o,
      output dmem_req_ready_i, dmem_rsp_valid_i, dmem_rsp_rdata_i, dmem_rsp_err_i
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one EX/MEM load/store on the data bus, stalling the pipeline until it completes.
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [63:0]       addr_i,
   input  logic [63:0]       store_data_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   lsu_ctrl_if.master        dmem,
   output logic              stall_o,
   output logic              load_valid_o,
   output logic [63:0]       load_data_o,
   output logic              misalign_o,
   output logic              bus_err_o
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t      state, state_nxt;
   logic        rst_q, we_q, uns_q, mis_q, err_q, kill_q;
   logic [1:0]  sz_q;
   logic [63:0] a_q, d_q, rdata_q;
   logic [15:0] cnt_q;
   logic        blocked, mis, go, abort, acc, rsp, tmo, req_on, fire, sgn;
   logic [5:0]  sh;
   logic [7:0]  be_base;
   logic [63:0] r, ext;
   always_comb begin
      blocked = rst | rst_q;
      mis = size_i == 2'd1 ? addr_i[0] : size_i == 2'd2 ? |addr_i[1:0] : size_i == 2'd3 ? |addr_i[2:0] : 1'b0;
      go = state == IDLE && !flush_i && (mem_read_i || mem_write_i) && !blocked;
      abort = state == REQ && flush_i && !dmem.dmem_req_ready_i;
      acc = state == REQ && dmem.dmem_req_ready_i;
      rsp = state == WAIT && dmem.dmem_rsp_valid_i;
      tmo = state == WAIT && !dmem.dmem_rsp_valid_i && cnt_q == 16'(TIMEOUT_CYCLES - 1);
   end
   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state   <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         d_q     <= '0;
         rdata_q <= '0;
         sz_q    <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go) begin
            a_q    <= addr_i;
            d_q    <= store_data_i;
            sz_q   <= size_i;
            uns_q  <= unsigned_i;
            we_q   <= mem_write_i;
            mis_q  <= mis;
            err_q  <= 1'b0;
            kill_q <= 1'b0;
         end
         if (acc) cnt_q <= '0;
         else if (state == WAIT) cnt_q <= cnt_q + 16'd1;
         // an accepted-but-flushed request still drains, so remember it is dead
         if ((acc || state == WAIT) && flush_i) kill_q <= 1'b1;
         if (rsp) begin
            rdata_q <= dmem.dmem_rsp_rdata_i;
            err_q   <= dmem.dmem_rsp_err_i;
         end else if (tmo) err_q <= 1'b1;
      end
   end
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = go ? (mis ? DONE : REQ) : IDLE;
         REQ:     state_nxt = abort ? IDLE : acc ? WAIT : REQ;
         WAIT:    state_nxt = (rsp || tmo) ? DONE : WAIT;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      sh = {a_q[2:0], 3'b000};
      be_base = sz_q == 2'd0 ? 8'h01 : sz_q == 2'd1 ? 8'h03 : sz_q == 2'd2 ? 8'h0F : 8'hFF;
      req_on = state == REQ && !abort && !blocked;
      dmem.dmem_req_valid_o = req_on;
      dmem.dmem_req_we_o    = req_on && we_q;
      dmem.dmem_req_addr_o  = req_on ? {a_q[63:3], 3'b000} : 64'd0;
      dmem.dmem_req_wdata_o = req_on ? d_q << sh : 64'd0;
      dmem.dmem_req_be_o    = req_on ? be_base << a_q[2:0] : 8'd0;
      stall_o = !blocked && (go || (state == REQ && !abort) || state == WAIT);
      fire = state == DONE && !kill_q && !blocked;
      misalign_o   = fire && mis_q;
      bus_err_o    = fire && !mis_q && err_q;
      load_valid_o = fire && !mis_q && !err_q && !we_q;
      sgn = !uns_q;
      r = rdata_q >> sh;
      ext = sz_q == 2'd0 ? {{56{sgn & r[7]}}, r[7:0]} :
            sz_q == 2'd1 ? {{48{sgn & r[15]}}, r[15:0]} :
            sz_q == 2'd2 ? {{32{sgn & r[31]}}, r[31:0]} : r;
      load_data_o = load_valid_o ? ext : 64'd0;
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized accesses checked against a byte-level reference model.
module tb_lsu_ctrl;
   localparam int T = 4;
   logic        clk = 1'b0;
   logic        rst, flush_i, mem_read_i, mem_write_i, unsigned_i;
   logic [63:0] addr_i, store_data_i;
   logic [1:0]  size_i;
   logic        stall_o, load_valid_o, misalign_o, bus_err_o;
   logic [63:0] load_data_o;
   int          checks = 0;
   int          failures = 0;
   lsu_ctrl_if dmem ();
   lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .addr_i(addr_i), .store_data_i(store_data_i), .size_i(size_i), .unsigned_i(unsigned_i),
      .dmem(dmem), .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic bit m_mis(input logic [63:0] a, input logic [1:0] sz);
      return (a % (64'd1 << sz)) != 0;
   endfunction
   function automatic logic [7:0] m_be(input logic [63:0] a, input logic [1:0] sz);
      logic [7:0] be = '0;
      int off = int'(a[2:0]);
      for (int i = 0; i < 8; i++) if (i >= off && i < off + (1 << sz)) be[i] = 1'b1;
      return be;
   endfunction
   function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] d);
      logic [63:0] w = '0;
      int off = int'(a[2:0]);
      for (int i = 0; i + off < 8; i++) w[(i + off) * 8 +: 8] = d[i * 8 +: 8];
      return w;
   endfunction
   function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] sz, input bit u, input logic [63:0] rd);
      logic [63:0] v = '0;
      int off = int'(a[2:0]);
      int n = 1 << sz;
      for (int i = 0; i < n; i++) v[i * 8 +: 8] = rd[(off + i) * 8 +: 8];
      if (!u && n < 8 && v[n * 8 - 1]) for (int i = n; i < 8; i++) v[i * 8 +: 8] = 8'hFF;
      return v;
   endfunction
   // mode 0: plain, 1: flush in first REQ cycle (needs rdly>=1), 2: flush in first WAIT cycle
   task automatic access(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] sz, input bit u, input int rdly, input int pdly,
                         input bit perr, input logic [63:0] rdata, input int mode);
      bit tmo = pdly >= T;
      int nw = tmo ? T : pdly + 1;
      bit killed = mode == 2;
      bit err = tmo || perr;
      @(negedge clk);
      mem_read_i = rd; mem_write_i = wr; addr_i = a; store_data_i = d; size_i = sz; unsigned_i = u;
      #1;
      chk("stall_idle", 64'(stall_o), 64'd1);
      chk("valid_idle", 64'(dmem.dmem_req_valid_o), 64'd0);
      if (m_mis(a, sz)) begin
         @(negedge clk);
         mem_read_i = 0; mem_write_i = 0;
         #1;
         chk("misalign_pulse", 64'(misalign_o), 64'd1);
         chk("misalign_stall", 64'(stall_o), 64'd0);
         chk("misalign_noreq", 64'(dmem.dmem_req_valid_o), 64'd0);
         chk("misalign_noerr", 64'(bus_err_o), 64'd0);
         chk("misalign_noload", 64'(load_valid_o), 64'd0);
         @(negedge clk);
         #1;
         chk("misalign_once", 64'(misalign_o), 64'd0);
         return;
      end
      for (int k = 0; k <= rdly; k++) begin
         @(negedge clk);
         dmem.dmem_req_ready_i = (k == rdly);
         if (mode == 1) begin
            dmem.dmem_req_ready_i = 0;
            flush_i = 1;
            #1;
            chk("flushreq_valid", 64'(dmem.dmem_req_valid_o), 64'd0);
            chk("flushreq_stall", 64'(stall_o), 64'd0);
            @(negedge clk);
            flush_i = 0; mem_read_i = 0; mem_write_i = 0;
            #1;
            chk("flushreq_idle_valid", 64'(dmem.dmem_req_valid_o), 64'd0);
            chk("flushreq_idle_stall", 64'(stall_o), 64'd0);
            return;
         end
         #1;
         chk("req_valid", 64'(dmem.dmem_req_valid_o), 64'd1);
         chk("req_we", 64'(dmem.dmem_req_we_o), 64'(wr));
         chk("req_addr", dmem.dmem_req_addr_o, a & ~64'd7);
         chk("req_be", 64'(dmem.dmem_req_be_o), 64'(m_be(a, sz)));
         chk("req_wdata", dmem.dmem_req_wdata_o, m_wdata(a, d));
         chk("req_stall", 64'(stall_o), 64'd1);
      end
      for (int w = 0; w < nw; w++) begin
         @(negedge clk);
         dmem.dmem_req_ready_i = 0;
         dmem.dmem_rsp_valid_i = !tmo && w == pdly;
         dmem.dmem_rsp_rdata_i = rdata;
         dmem.dmem_rsp_err_i = perr;
         flush_i = mode == 2 && w == 0;
         if (flush_i) begin mem_read_i = 0; mem_write_i = 0; end
         #1;
         chk("wait_stall", 64'(stall_o), 64'd1);
         chk("wait_valid", 64'(dmem.dmem_req_valid_o), 64'd0);
      end
      @(negedge clk);
      dmem.dmem_rsp_valid_i = 0; flush_i = 0; mem_read_i = 0; mem_write_i = 0;
      #1;
      chk("done_stall", 64'(stall_o), 64'd0);
      chk("done_misalign", 64'(misalign_o), 64'd0);
      chk("done_bus_err", 64'(bus_err_o), 64'(!killed && err));
      chk("done_load_valid", 64'(load_valid_o), 64'(!killed && !err && !wr));
      if (!killed && !err && !wr) chk("done_load_data", load_data_o, m_load(a, sz, u, rdata));
      if (tmo) begin
         @(negedge clk);
         dmem.dmem_rsp_valid_i = 1;
         #1;
         chk("late_rsp_load", 64'(load_valid_o), 64'd0);
         chk("late_rsp_err", 64'(bus_err_o), 64'd0);
         chk("late_rsp_stall", 64'(stall_o), 64'd0);
         @(negedge clk);
         dmem.dmem_rsp_valid_i = 0;
         #1;
         chk("late_rsp_quiet", 64'(load_valid_o | bus_err_o), 64'd0);
      end
   endtask
   initial begin
      rst = 1; flush_i = 0; mem_read_i = 1; mem_write_i = 0; unsigned_i = 0;
      addr_i = '0; store_data_i = '0; size_i = '0;
      dmem.dmem_req_ready_i = 0; dmem.dmem_rsp_valid_i = 0; dmem.dmem_rsp_rdata_i = '0; dmem.dmem_rsp_err_i = 0;
      @(negedge clk);
      #1;
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_valid", 64'(dmem.dmem_req_valid_o), 64'd0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("postrst_stall", 64'(stall_o), 64'd0);
      chk("postrst_outs", 64'(load_valid_o | misalign_o | bus_err_o), 64'd0);
      @(negedge clk);
      mem_read_i = 0;
      #1;
      chk("postrst_nolaunch", 64'(dmem.dmem_req_valid_o), 64'd0);
      access(1, 0, 64'h1004, 64'h0, 2'd2, 0, 0, 0, 0, 64'h80000000_00000000, 0);
      access(0, 1, 64'h2003, 64'hAB, 2'd0, 0, 2, 1, 0, 64'h0, 0);
      access(1, 0, 64'h3001, 64'h0, 2'd1, 0, 0, 0, 0, 64'h0, 0);
      access(1, 0, 64'h4000, 64'h0, 2'd3, 0, 0, 9, 0, 64'h0, 0);
      access(1, 0, 64'h5008, 64'h0, 2'd3, 0, 1, 0, 0, 64'h0, 1);
      access(1, 0, 64'h6006, 64'h0, 2'd1, 0, 0, 1, 0, 64'hFFFF_0000_0000_0000, 2);
      access(1, 0, 64'h7002, 64'h0, 2'd1, 1, 0, 0, 0, 64'h0000_0000_8001_0000, 0);
      access(1, 1, 64'h8004, 64'h1234_5678, 2'd2, 0, 0, 2, 1, 64'h0, 0);
      // reset while a load is outstanding in WAIT
      @(negedge clk);
      mem_read_i = 1; addr_i = 64'h9000; size_i = 2'd3;
      @(negedge clk);
      dmem.dmem_req_ready_i = 1;
      @(negedge clk);
      dmem.dmem_req_ready_i = 0; rst = 1;
      #1;
      chk("rstwait_stall", 64'(stall_o), 64'd0);
      chk("rstwait_outs", 64'(load_valid_o | misalign_o | bus_err_o | dmem.dmem_req_valid_o), 64'd0);
      @(negedge clk);
      rst = 0; mem_read_i = 0; dmem.dmem_rsp_valid_i = 1;
      #1;
      chk("rstwait_after_stall", 64'(stall_o), 64'd0);
      chk("rstwait_after_load", 64'(load_valid_o | bus_err_o), 64'd0);
      @(negedge clk);
      dmem.dmem_rsp_valid_i = 0;
      #1;
      chk("rstwait_idle", 64'(stall_o | load_valid_o | dmem.dmem_req_valid_o), 64'd0);
      for (int n = 0; n < 60; n++) begin
         int kind = $urandom_range(0, 2);
         int rdly = $urandom_range(0, 3);
         int mode = $urandom_range(0, 5);
         logic [63:0] a = {$urandom, $urandom};
         logic [63:0] d = {$urandom, $urandom};
         logic [63:0] rd = {$urandom, $urandom};
         mode = mode == 4 ? (rdly >= 1 ? 1 : 0) : mode == 5 ? 2 : 0;
         access(kind != 1, kind != 0, a, d, 2'($urandom_range(0, 3)), 1'($urandom), rdly,
                $urandom_range(0, 5), $urandom_range(0, 7) == 0, rd, mode);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
